// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: streams operands LSB-first through an external
// 1-bit ALU slice and reassembles the WIDTH-bit result.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, a_in, b_in       request and operands, captured in IDLE
//   SELECT, INVERTB         op select (00 AND, 01 OR, 1x ADD), invert B
//   slice_a/b/invb/cin/sel  drive to the 1-bit slice (zero outside RUN)
//   slice_out, slice_cout   combinational slice result and carry
//   busy, done              RUN indicator, one-cycle completion pulse
//   result, carry_out       final result and MSB carry, held until next op
//   overflow, zero          status flags
//
// Build option: define ALU_SERIAL_FLAGS_EN to enable the overflow/zero
// flags; otherwise both outputs are tied to 0.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       SELECT,
    input  logic             INVERTB,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_invb,
    output logic             slice_cin,
    output logic [1:0]       slice_sel,
    input  logic             slice_out,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       sel_q, sel_d;
    logic             invb_q, invb_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run;

`ifdef ALU_SERIAL_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;
`endif

    assign run = (state_q == S_RUN);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        result_d = result_q;
        sel_d    = sel_q;
        invb_d   = invb_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
`ifdef ALU_SERIAL_FLAGS_EN
        ovf_d    = ovf_q;
        zero_d   = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a_in;
                    b_d     = b_in;
                    sh_d    = '0;
                    sel_d   = SELECT;
                    invb_d  = INVERTB;
                    cnt_d   = '0;
                    // subtract = add inverted B with carry-in of one
                    carry_d = INVERTB & SELECT[1];
                end
            end
            S_RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sh_d    = {slice_out, sh_q[WIDTH-1:1]};
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    // counter holds at LAST so it never wraps
                    state_d  = S_DONE;
                    result_d = {slice_out, sh_q[WIDTH-1:1]};
                    cout_d   = sel_q[1] & slice_cout;
`ifdef ALU_SERIAL_FLAGS_EN
                    // carry_q is the carry into the MSB here
                    ovf_d  = sel_q[1] & (carry_q ^ slice_cout);
                    zero_d = ({slice_out, sh_q[WIDTH-1:1]} == '0);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            result_q <= '0;
            sel_q    <= '0;
            invb_q   <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            sel_q    <= sel_d;
            invb_q   <= invb_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ALU_SERIAL_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end
    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

    assign slice_a    = run & a_q[0];
    assign slice_b    = run & b_q[0];
    assign slice_cin  = run & carry_q;
    assign slice_invb = run & invb_q;
    assign slice_sel  = run ? sel_q : 2'b00;

    assign busy      = run;
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Testbench for alu_serial_ctrl with a reference 1-bit slice attached.
// Expected values come from whole-word arithmetic on the operands.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic [1:0]   sel_in;
    logic         invb_in;
    logic         slice_a, slice_b, slice_invb, slice_cin;
    logic [1:0]   slice_sel;
    logic         slice_out, slice_cout;
    logic         busy, done;
    logic [W-1:0] result;
    logic         carry_out, overflow, zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .SELECT     (sel_in),
        .INVERTB    (invb_in),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_invb (slice_invb),
        .slice_cin  (slice_cin),
        .slice_sel  (slice_sel),
        .slice_out  (slice_out),
        .slice_cout (slice_cout),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    // reference 1-bit ALU slice
    always_comb begin
        logic bx;
        bx = slice_b ^ slice_invb;
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_sel)
            2'b00: slice_out = slice_a & bx;
            2'b01: slice_out = slice_a | bx;
            default: begin
                slice_out  = slice_a ^ bx ^ slice_cin;
                slice_cout = (slice_a & bx) | (slice_a & slice_cin)
                           | (bx & slice_cin);
            end
        endcase
    end

    // whole-word model of one operation
    task automatic ref_op(
        input  logic [W-1:0] a, b,
        input  logic [1:0]   s,
        input  logic         ib,
        output logic [W-1:0] r,
        output logic         c, o, z
    );
        logic [W-1:0] bb;
        logic [W:0]   sum;
        bb = ib ? ~b : b;
        o  = 1'b0;
        c  = 1'b0;
        if (s == 2'b00) begin
            r = a & bb;
        end else if (s == 2'b01) begin
            r = a | bb;
        end else begin
            sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ib};
            r   = sum[W-1:0];
            c   = sum[W];
            o   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        end
        z = (r == '0);
`ifndef ALU_SERIAL_FLAGS_EN
        o = 1'b0;
        z = 1'b0;
`endif
    endtask

    // issue one op at the current negedge, scramble inputs while it runs,
    // wait (bounded) for done, then step into the following IDLE cycle
    task automatic do_op(
        input  logic [W-1:0] a, b,
        input  logic [1:0]   s,
        input  logic         ib,
        output int           lat,
        output int           nbusy,
        output logic         d2,
        output logic [W-1:0] r,
        output logic         c, o, z
    );
        bit got;
        start   = 1'b1;
        a_in    = a;
        b_in    = b;
        sel_in  = s;
        invb_in = ib;
        lat   = 0;
        nbusy = 0;
        got   = 1'b0;
        r = 'x; c = 1'bx; o = 1'bx; z = 1'bx;
        for (int i = 1; i <= W + 5 && !got; i++) begin
            @(negedge clk);
            start   = 1'b0;
            a_in    = W'($urandom);
            b_in    = W'($urandom);
            sel_in  = 2'($urandom);
            invb_in = 1'($urandom);
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1;
                lat = i;
                r = result; c = carry_out; o = overflow; z = zero;
            end
        end
        if (!got) lat = -1;
        @(negedge clk);
        d2 = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a_in = '0; b_in = '0; sel_in = '0; invb_in = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, result, carry_out, overflow, zero} !== '0) begin
            bad++;
            $display("FAIL reset_outs: got b%0b d%0b r%h c%0b o%0b z%0b want all 0",
                     busy, done, result, carry_out, overflow, zero);
        end
        total++;
        if ({slice_a, slice_b, slice_invb, slice_cin, slice_sel} !== '0) begin
            bad++;
            $display("FAIL reset_slice: got %b want 000000",
                     {slice_a, slice_b, slice_invb, slice_cin, slice_sel});
        end
        // reset wins over a simultaneous start
        start = 1'b1; a_in = 8'h11; b_in = 8'h22; sel_in = 2'b10;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_prio: got busy=%0b want 0", busy);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [7] = '{8'h3C, 8'h05, 8'h07, 8'h7F, 8'hF0, 8'hF0, 8'h80};
        logic [W-1:0] tb [7] = '{8'h05, 8'h07, 8'h07, 8'h01, 8'h3C, 8'h3C, 8'h01};
        logic [1:0]   ts [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
        logic         ti [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            int lat, nb;
            logic d2, c, o, z, ec, eo, ez;
            logic [W-1:0] r, er;
            ref_op(ta[k], tb[k], ts[k], ti[k], er, ec, eo, ez);
            do_op(ta[k], tb[k], ts[k], ti[k], lat, nb, d2, r, c, o, z);
            total++;
            if (lat !== W + 1) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, W + 1);
            end
            total++;
            if ({r, c, o, z} !== {er, ec, eo, ez}) begin
                bad++;
                $display("FAIL dir%0d_result: got r%h c%0b o%0b z%0b want r%h c%0b o%0b z%0b",
                         k, r, c, o, z, er, ec, eo, ez);
            end
            total++;
            if (nb !== W || d2 !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_busy_pulse: got busy=%0d done2=%0b want %0d 0",
                         k, nb, d2, W);
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 25; k++) begin
            int lat, nb;
            logic d2, c, o, z, ec, eo, ez;
            logic [W-1:0] r, er, a, b;
            logic [1:0] s;
            logic ib;
            a = W'($urandom); b = W'($urandom);
            s = 2'($urandom); ib = 1'($urandom);
            ref_op(a, b, s, ib, er, ec, eo, ez);
            do_op(a, b, s, ib, lat, nb, d2, r, c, o, z);
            total++;
            if (lat !== W + 1 || {r, c, o, z} !== {er, ec, eo, ez}) begin
                bad++;
                $display("FAIL rnd%0d: got lat%0d r%h c%0b o%0b z%0b want lat%0d r%h c%0b o%0b z%0b",
                         k, lat, r, c, o, z, W + 1, er, ec, eo, ez);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [W-1:0] er;
        logic ec, eo, ez;
        int ndone = 0;
        ref_op(8'h3C, 8'h05, 2'b10, 1'b0, er, ec, eo, ez);
        start = 1'b1; a_in = 8'h3C; b_in = 8'h05; sel_in = 2'b10; invb_in = 1'b0;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (done) ndone++;
            start = (i == 3 || i == 9);
            a_in  = 8'hFF; b_in = 8'hFF; sel_in = 2'b01; invb_in = 1'b1;
        end
        start = 1'b0;
        total++;
        if (ndone !== 1) begin
            bad++;
            $display("FAIL ignore_ndone: got %0d want 1", ndone);
        end
        total++;
        if (result !== er || carry_out !== ec || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_result: got r%h c%0b busy%0b want r%h c%0b busy0",
                     result, carry_out, busy, er, ec);
        end
    endtask

    task automatic test_mid_reset;
        int ndone = 0;
        int lat, nb;
        logic d2, c, o, z, ec, eo, ez;
        logic [W-1:0] r, er;
        start = 1'b1; a_in = 8'h7F; b_in = 8'h01; sel_in = 2'b10; invb_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 4) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({busy, done, result, carry_out, overflow, zero} !== '0) begin
            bad++;
            $display("FAIL midrst_outs: got b%0b d%0b r%h c%0b o%0b z%0b want all 0",
                     busy, done, result, carry_out, overflow, zero);
        end
        total++;
        if ({slice_a, slice_b, slice_invb, slice_cin, slice_sel} !== '0) begin
            bad++;
            $display("FAIL midrst_slice: got %b want 000000",
                     {slice_a, slice_b, slice_invb, slice_cin, slice_sel});
        end
        repeat (W + 3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++;
            $display("FAIL midrst_nodone: got %0d want 0", ndone);
        end
        ref_op(8'h07, 8'h07, 2'b10, 1'b1, er, ec, eo, ez);
        do_op(8'h07, 8'h07, 2'b10, 1'b1, lat, nb, d2, r, c, o, z);
        total++;
        if (lat !== W + 1 || {r, c, o, z} !== {er, ec, eo, ez}) begin
            bad++;
            $display("FAIL midrst_after: got lat%0d r%h c%0b o%0b z%0b want lat%0d r%h c%0b o%0b z%0b",
                     lat, r, c, o, z, W + 1, er, ec, eo, ez);
        end
    endtask

    task automatic test_back_to_back;
        int t0, t1;
        for (int k = 0; k < 4; k++) begin
            int lat, nb;
            logic d2, c, o, z, ec, eo, ez;
            logic [W-1:0] r, er, a, b;
            a = W'($urandom); b = W'($urandom);
            ref_op(a, b, 2'b11, 1'b0, er, ec, eo, ez);
            t0 = int'($time);
            do_op(a, b, 2'b11, 1'b0, lat, nb, d2, r, c, o, z);
            t1 = int'($time);
            total++;
            if (lat !== W + 1 || (t1 - t0) !== (W + 2) * 10 || r !== er || c !== ec) begin
                bad++;
                $display("FAIL b2b%0d: got lat%0d dt%0d r%h c%0b want lat%0d dt%0d r%h c%0b",
                         k, lat, t1 - t0, r, c, W + 1, (W + 2) * 10, er, ec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  operand A, captured on accepted start.
REQ-006 b_in  input  WIDTH  operand B, captured on accepted start.
REQ-007 SELECT  input  2  op: 00 AND, 01 OR, 10/11 ADD; captured on accepted start.
REQ-008 INVERTB  input  1  invert B (SUB when SELECT[1]=1); captured on accepted start.
REQ-009 slice_a, slice_b, slice_invb, slice_cin  output  1 each  drive to the downstream 1-bit ALU slice.
REQ-010 slice_sel  output  2  SELECT to the slice.
REQ-011 slice_out, slice_cout  input  1 each  combinational result/carry from the slice.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse, result valid.
REQ-014 result  output  WIDTH  final result, held until next accepted start.
REQ-015 carry_out  output  1  slice carry from MSB bit.
REQ-016 overflow, zero  output  1 each  status flags (see REQ-031).

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after bit WIDTH-1 processed; DONE->IDLE unconditionally next cycle.
REQ-018 Accepted start (cycle 0) shall load A/B shift registers, latched SELECT/INVERTB, bit counter=0, carry register = INVERTB & SELECT[1].
REQ-019 In RUN, slice_a/slice_b shall be bit 0 of the A/B shift registers, slice_cin the carry register, slice_sel/slice_invb the latched values.
REQ-020 Each RUN cycle: shift A/B right by one, shift slice_out into MSB of result shift register, carry register <= slice_cout, counter +1.
REQ-021 Bit k processed in cycle k+1; DONE in cycle WIDTH+1 with done=1 and result/carry_out/flags valid; latency start-to-done = WIDTH+1 cycles.
REQ-022 carry_out shall capture slice_cout of bit WIDTH-1; 0 for AND/OR.
REQ-023 start while busy or in DONE shall be ignored; inputs changing during RUN shall have no effect.
REQ-024 Back-to-back: start may be accepted in the cycle after DONE (IDLE); minimum issue interval WIDTH+2 cycles.
REQ-025 Outside RUN, slice_a, slice_b, slice_cin, slice_invb shall be 0 and slice_sel 00.
REQ-026 Counter shall be wide enough for WIDTH-1 and never wrap during RUN.

Reset
REQ-027 rst_n=0 at a rising edge shall force IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0, all internal registers 0.
REQ-028 Reset mid-RUN shall abort the operation; no done pulse shall be produced for it.
REQ-029 Reset shall take priority over start in the same cycle.

Configuration
REQ-030 Macro ALU_SERIAL_FLAGS_EN selects status-flag logic.
REQ-031 With ALU_SERIAL_FLAGS_EN defined: overflow = carry into MSB XOR carry_out for SELECT[1]=1, else 0; zero = (result==0); both updated with result in DONE and held.
REQ-032 Without ALU_SERIAL_FLAGS_EN: overflow and zero tied to 0; no flag registers synthesized.

Verification (WIDTH=8, slice = reference 1-bit ALU)
REQ-033 ADD 8'h3C+8'h05, INVERTB=0 -> done at cycle 9, result 8'h41, carry_out 0, overflow 0.
REQ-034 SUB 8'h05-8'h07 (SELECT=10, INVERTB=1) -> result 8'hFE, carry_out 0; 8'h07-8'h07 -> 8'h00, carry_out 1, zero 1 (flags enabled).
REQ-035 ADD 8'h7F+8'h01 -> result 8'h80, overflow 1 with macro, 0 without.
REQ-036 AND 8'hF0&8'h3C -> 8'h30; OR -> 8'hFC; carry_out 0 both.
REQ-037 start pulsed at cycles 3 and 9 of a running op -> ignored, single done, result unchanged.
REQ-038 rst_n=0 at cycle 4 of RUN -> IDLE next cycle, all outputs 0, no done; new start then completes normally.
